// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline controller: exception codes,
// vector offsets, FSM state type and the exception vector lookup.
package ctrl_pkg;

    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;
    localparam logic [31:0] EXC_BREAK   = 32'h0000_000f;
    localparam logic [31:0] EXC_ADEL_I  = 32'h0000_0010;
    localparam logic [31:0] EXC_ADEL    = 32'h0000_0011;
    localparam logic [31:0] EXC_ADES    = 32'h0000_0012;

    localparam logic [11:0] VEC_INT = 12'h000;
    localparam logic [11:0] VEC_GEN = 12'h180;

    typedef enum logic {
        IDLE,
        HOLD
    } ctrl_state_e;

    typedef struct packed {
        logic        hit;
        logic [31:0] target;
    } exc_vec_t;

    // Map an exception code to its redirect target; hit=0 for none/unknown.
    function automatic exc_vec_t exc_lookup(input logic [31:0] code,
                                            input logic [19:0] ebase_hi,
                                            input logic [31:0] epc);
        exc_vec_t r;
        r = '0;
        case (code)
            EXC_INT: begin
                r.hit    = 1'b1;
                r.target = {ebase_hi, VEC_INT};
            end
            EXC_SYSCALL, EXC_RI, EXC_OV, EXC_BREAK,
            EXC_ADEL_I, EXC_ADEL, EXC_ADES: begin
                r.hit    = 1'b1;
                r.target = {ebase_hi, VEC_GEN};
            end
            EXC_ERET: begin
                r.hit    = 1'b1;
                r.target = epc;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_v2_if.sv
// Bus between the pipeline datapath and the pipeline controller.
interface pipeline_ctrl_v2_if #(
    parameter int unsigned NUM_STAGES = 6
);
    logic [31:0]           excepttype_i;
    logic [31:0]           cp0_epc_i;
    logic [31:0]           cp0_ebase_i;
    logic [NUM_STAGES-1:0] stallreq_i;
    logic [NUM_STAGES-1:0] stall;
    logic                  flush;
    logic [31:0]           new_pc;
    logic                  exc_busy_o;
    logic                  unknown_exc_o;
    logic                  stall_timeout_o;

    // Datapath side: raises requests, consumes stall/flush.
    modport master (
        output excepttype_i, cp0_epc_i, cp0_ebase_i, stallreq_i,
        input  stall, flush, new_pc, exc_busy_o, unknown_exc_o, stall_timeout_o
    );

    // Controller side.
    modport slave (
        input  excepttype_i, cp0_epc_i, cp0_ebase_i, stallreq_i,
        output stall, flush, new_pc, exc_busy_o, unknown_exc_o, stall_timeout_o
    );
endinterface

// File: rtl/pipeline_ctrl_v2_watchdog.sv
// Stall watchdog: counts consecutive stalled, non-flushed cycles and emits
// a single registered pulse when the count reaches STALL_TIMEOUT.
module stall_watchdog #(
    parameter int unsigned STALL_TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active,
    output logic timeout_pulse
);
    localparam logic [9:0] LIMIT = 10'(STALL_TIMEOUT);

    logic [9:0] cnt_q, cnt_d;
    logic       pulse_q, pulse_d;

    // Next count: clear when not stalling, saturate at the limit.
    always_comb begin
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (stall_active && (LIMIT != '0)) begin
            if (cnt_q == LIMIT) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d   = cnt_q + 10'd1;
                pulse_d = (cnt_d == LIMIT);
            end
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign timeout_pulse = pulse_q & ~rst;

endmodule

// File: rtl/pipeline_ctrl_v2.sv
// Pipeline controller: exception redirect with optional flush hold,
// thermometer stall generation and a stall watchdog.
module pipeline_ctrl_v2
    import ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES    = 6,
    parameter int unsigned FLUSH_HOLD    = 1,
    parameter int unsigned STALL_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    pipeline_ctrl_v2_if.slave bus
);
    ctrl_state_e           state_q, state_d;
    logic [3:0]            hold_q, hold_d;
    logic [31:0]           target_q, target_d;
    logic                  unknown_q, unknown_d;
    exc_vec_t              vec;
    logic [NUM_STAGES-1:0] therm;
    logic                  therm_seen;
    logic [NUM_STAGES-1:0] stall_c;
    logic                  flush_c;
    logic [31:0]           new_pc_c;
    logic                  busy_c;
    logic                  wd_pulse;

    assign vec = exc_lookup(bus.excepttype_i, bus.cp0_ebase_i[31:12], bus.cp0_epc_i);

    // Thermometer mask: every stage at or below the highest requester holds.
    always_comb begin
        therm      = '0;
        therm_seen = 1'b0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            therm_seen                = therm_seen | bus.stallreq_i[NUM_STAGES-1-i];
            therm[NUM_STAGES-1-i]     = therm_seen;
        end
    end

    // Next state and combinational outputs; rst forces every output low.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        target_d  = target_q;
        unknown_d = 1'b0;
        stall_c   = '0;
        flush_c   = 1'b0;
        new_pc_c  = '0;
        busy_c    = 1'b0;
        if (!rst) begin
            case (state_q)
                HOLD: begin
                    flush_c  = 1'b1;
                    new_pc_c = target_q;
                    busy_c   = 1'b1;
                    if (hold_q == 4'd1) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q - 4'd1;
                    end
                end
                default: begin
                    if (vec.hit) begin
                        flush_c  = 1'b1;
                        new_pc_c = vec.target;
                        target_d = vec.target;
                        if (FLUSH_HOLD != 0) begin
                            state_d = HOLD;
                            hold_d  = 4'(FLUSH_HOLD);
                        end
                    end else begin
                        stall_c   = therm;
                        unknown_d = (bus.excepttype_i != '0);
                    end
                end
            endcase
        end
    end

    // State, hold counter, latched target and unknown-code pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            target_q  <= '0;
            unknown_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            target_q  <= target_d;
            unknown_q <= unknown_d;
        end
    end

    stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .stall_active ((stall_c != '0) && !flush_c),
        .timeout_pulse(wd_pulse)
    );

    assign bus.stall           = stall_c;
    assign bus.flush           = flush_c;
    assign bus.new_pc          = new_pc_c;
    assign bus.exc_busy_o      = busy_c;
    assign bus.unknown_exc_o   = unknown_q & ~rst;
    assign bus.stall_timeout_o = wd_pulse;

endmodule
